// File: rtl/window_fill_buffer.sv
// Packs three 32-bit row words (4 pixels each) into the 12-byte edge-detector window.
// Raises ready/full when the window completes and empties it on buffer_clear.
module window_fill_buffer #(
    parameter int unsigned NUM_ROWS = 3,
    parameter int unsigned PIX_W    = 8
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               start_window,
    input  logic [31:0]                        read_data,
    input  logic                               transfer_data_complete_r,
    input  logic                               buffer_clear,
    output logic [NUM_ROWS*4-1:0][PIX_W-1:0]   data_buffer,
    output logic [1:0]                         rows_loaded,
    output logic                               window_ready,
    output logic                               buffer_full,
    output logic                               overflow
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } state_t;

    state_t                             state, state_n;
    logic [NUM_ROWS*4-1:0][PIX_W-1:0]   buf_n;
    logic [1:0]                         rows_n;
    logic                               ready_n;
    logic                               full_n;
    logic                               ovf_n;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= IDLE;
            data_buffer  <= '0;
            rows_loaded  <= '0;
            window_ready <= 1'b0;
            buffer_full  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_n;
            data_buffer  <= buf_n;
            rows_loaded  <= rows_n;
            window_ready <= ready_n;
            buffer_full  <= full_n;
            overflow     <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        buf_n   = data_buffer;
        rows_n  = rows_loaded;
        ready_n = 1'b0;
        full_n  = buffer_full;
        ovf_n   = overflow;

        // buffer_clear outranks start and strobe; overflow deliberately survives it
        if (buffer_clear) begin
            state_n = IDLE;
            buf_n   = '0;
            rows_n  = '0;
            full_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_window) begin
                        state_n = FILL;
                        rows_n  = '0;
                        ovf_n   = 1'b0;
                    end
                end
                FILL: begin
                    if (start_window) begin
                        rows_n = '0;
                        ovf_n  = 1'b0;
                    end else if (transfer_data_complete_r) begin
                        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                            if (rows_loaded == 2'(r)) begin
                                for (int unsigned k = 0; k < 4; k++) begin
                                    buf_n[4*r+k] = read_data[PIX_W*k +: PIX_W];
                                end
                            end
                        end
                        rows_n = rows_loaded + 2'd1;
                        if (rows_loaded == 2'(NUM_ROWS - 1)) begin
                            state_n = FULL;
                            full_n  = 1'b1;
                            ready_n = 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (transfer_data_complete_r) begin
                        ovf_n = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_fill_buffer.sv
// Scoreboard bench for window_fill_buffer: a behavioural model queues the expected
// registered outputs per cycle; they are compared one time unit after the edge.
module tb_window_fill_buffer;

    logic               clk;
    logic               n_rst;
    logic               start_window;
    logic [31:0]        read_data;
    logic               transfer_data_complete_r;
    logic               buffer_clear;
    logic [11:0][7:0]   data_buffer;
    logic [1:0]         rows_loaded;
    logic               window_ready;
    logic               buffer_full;
    logic               overflow;

    window_fill_buffer #(.NUM_ROWS(3), .PIX_W(8)) dut (
        .clk                      (clk),
        .n_rst                    (n_rst),
        .start_window             (start_window),
        .read_data                (read_data),
        .transfer_data_complete_r (transfer_data_complete_r),
        .buffer_clear             (buffer_clear),
        .data_buffer              (data_buffer),
        .rows_loaded              (rows_loaded),
        .window_ready             (window_ready),
        .buffer_full              (buffer_full),
        .overflow                 (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] data;
        logic [1:0]  rows;
        logic        ready;
        logic        full;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // model state: 0 idle, 1 filling, 2 full
    int          m_state = 0;
    logic [11:0][7:0] m_buf = '0;
    int          m_rows = 0;
    logic        m_ready = 1'b0;
    logic        m_full = 1'b0;
    logic        m_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic rst, input logic st, input logic stb,
                         input logic [31:0] d, input logic clr);
        if (!rst) begin
            m_state = 0; m_buf = '0; m_rows = 0;
            m_ready = 0; m_full = 0; m_ovf = 0;
        end else if (clr) begin
            m_state = 0; m_buf = '0; m_rows = 0;
            m_ready = 0; m_full = 0;
        end else begin
            m_ready = 0;
            if (m_state == 0) begin
                if (st) begin m_state = 1; m_rows = 0; m_ovf = 0; end
            end else if (m_state == 1) begin
                if (st) begin
                    m_rows = 0; m_ovf = 0;
                end else if (stb) begin
                    for (int k = 0; k < 4; k++) m_buf[4*m_rows+k] = d[8*k +: 8];
                    m_rows = m_rows + 1;
                    if (m_rows == 3) begin m_state = 2; m_full = 1; m_ready = 1; end
                end
            end else begin
                if (stb) m_ovf = 1;
            end
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic st, input logic stb,
                        input logic [31:0] d, input logic clr);
        exp_t e;
        @(negedge clk);
        n_rst = rst; start_window = st; transfer_data_complete_r = stb;
        read_data = d; buffer_clear = clr;
        model(rst, st, stb, d, clr);
        e.data = m_buf; e.rows = 2'(m_rows); e.ready = m_ready; e.full = m_full; e.ovf = m_ovf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, ".data"},  96'(data_buffer),  e.data);
        check_eq({tag, ".rows"},  96'(rows_loaded),  96'(e.rows));
        check_eq({tag, ".ready"}, 96'(window_ready), 96'(e.ready));
        check_eq({tag, ".full"},  96'(buffer_full),  96'(e.full));
        check_eq({tag, ".ovf"},   96'(overflow),     96'(e.ovf));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask
    task automatic start(input string tag);
        step(tag, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask
    task automatic strobe(input string tag, input logic [31:0] d);
        step(tag, 1'b1, 1'b0, 1'b1, d, 1'b0);
    endtask
    task automatic clear(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst = 1'b0; start_window = 1'b0; transfer_data_complete_r = 1'b0;
        read_data = '0; buffer_clear = 1'b0;

        step("rst0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("rst1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("rst_zero", 96'(data_buffer), 96'h0);

        // window 1
        start("t1.start");
        strobe("t1.s0", 32'h64646464);
        check_eq("t1.rows1", 96'(rows_loaded), 96'd1);
        strobe("t1.s1", 32'h64C8C8C8);
        check_eq("t1.rows2", 96'(rows_loaded), 96'd2);
        strobe("t1.s2", 32'hC8C8C8C8);
        check_eq("t1.ready", 96'(window_ready), 96'd1);
        check_eq("t1.window", 96'(data_buffer), 96'hC8C8C8C8_64C8C8C8_64646464);
        idle("t1.hold");
        check_eq("t1.ready_drop", 96'(window_ready), 96'd0);
        check_eq("t1.full_hold", 96'(buffer_full), 96'd1);

        // clear then second window
        clear("t2.clr");
        check_eq("t2.cleared", 96'(data_buffer), 96'h0);
        strobe("t2.idle_stb", 32'h12345678);
        start("t2.start");
        strobe("t2.s0", 32'h64303887);
        strobe("t2.s1", 32'h500A3132);
        strobe("t2.s2", 32'h964662A5);
        check_eq("t2.window", 96'(data_buffer), 96'h964662A5_500A3132_64303887);

        // overflow while full
        strobe("t3.ovf", 32'hFFFFFFFF);
        check_eq("t3.ovf_set", 96'(overflow), 96'd1);
        check_eq("t3.unchanged", 96'(data_buffer), 96'h964662A5_500A3132_64303887);
        start("t3.start_ign");
        clear("t3.clr");
        check_eq("t3.ovf_keep", 96'(overflow), 96'd1);
        start("t3.restart");
        check_eq("t3.ovf_clr", 96'(overflow), 96'd0);

        // start and strobe collide
        strobe("t4.s0", 32'h11111111);
        strobe("t4.s1", 32'h22222222);
        step("t4.collide", 1'b1, 1'b1, 1'b1, 32'h33333333, 1'b0);
        check_eq("t4.rows0", 96'(rows_loaded), 96'd0);
        strobe("t4.s2", 32'hA0A1A2A3);
        strobe("t4.s3", 32'hB0B1B2B3);
        strobe("t4.s4", 32'hC0C1C2C3);
        check_eq("t4.window", 96'(data_buffer), 96'hC0C1C2C3_B0B1B2B3_A0A1A2A3);
        idle("t4.hold");

        // clear together with strobe mid-fill
        clear("t5.clr0");
        start("t5.start");
        strobe("t5.s0", 32'h01020304);
        strobe("t5.s1", 32'h05060708);
        step("t5.clr_stb", 1'b1, 1'b0, 1'b1, 32'h99999999, 1'b1);
        check_eq("t5.cleared", 96'(data_buffer), 96'h0);
        strobe("t5.idle_stb", 32'h99999999);

        // reset while full with overflow
        start("t6.start");
        strobe("t6.s0", 32'hDEADBEEF);
        strobe("t6.s1", 32'hCAFEF00D);
        strobe("t6.s2", 32'h0BADC0DE);
        strobe("t6.ovf", 32'h55555555);
        step("t6.rst", 1'b0, 1'b0, 1'b1, 32'h77777777, 1'b0);
        check_eq("t6.rst_ovf", 96'(overflow), 96'd0);
        strobe("t6.idle_s0", 32'h12121212);
        strobe("t6.idle_s1", 32'h34343434);
        check_eq("t6.still_zero", 96'(data_buffer), 96'h0);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step("rnd", 1'b1,
                 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)),
                 $urandom(),
                 1'($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
